// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------------------------
// clk_rst_seq
//   Reset / clock-enable sequencer for the clk_100M domain.
//   Synchronises the DCM lock indication, qualifies it as stable for LOCK_STABLE_CYC cycles,
//   then releases N_DOM downstream domain resets one at a time (bit 0 first), REL_GAP_CYC
//   cycles apart. Once every domain is out of reset the block sits in RUN and produces
//   single-cycle tick_1M / tick_100K enables. Lock loss or a software request while releasing
//   or running puts every domain back into reset and restarts the sequence.
//
//   Optional feature (compile-time macro CLK_SEQ_WDOG_EN):
//     lock-acquire watchdog. WDOG_CYC cycles spent in WAIT_LOCK+STABLE without reaching
//     RELEASE lands in FAULT, which only i_rst can leave. Without the macro there is no
//     watchdog, no FAULT state and o_lock_fault is tied low.
//
// Ports
//   i_clk_100M       in   1      system clock
//   i_rst            in   1      synchronous reset, active-high
//   i_dcm_lock       in   1      DCM locked, asynchronous (2-FF synchronised here)
//   i_sw_reset_req   in   1      1-cycle pulse: re-run the reset sequence
//   o_dom_rst        out  N_DOM  per-domain reset, active-high, bit 0 releases first
//   o_seq_done       out  1      high while in RUN
//   o_tick_1M        out  1      1-cycle enable every DIV_1M cycles
//   o_tick_100K      out  1      1-cycle enable every DIV_1M*DIV_100K cycles
//   o_seq_state      out  3      FSM state (0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN, 4 FAULT)
//   o_lock_loss_cnt  out  8      lock-loss aborts since reset, saturating at 255
//   o_lock_fault     out  1      watchdog expired, sticky until reset
// ---------------------------------------------------------------------------------------------
module clk_rst_seq #(
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned REL_GAP_CYC     = 16,
    parameter int unsigned N_DOM           = 4,
    parameter int unsigned DIV_1M          = 100,
    parameter int unsigned DIV_100K        = 10,
    parameter int unsigned WDOG_CYC        = 1000000
) (
    input  logic             i_clk_100M,
    input  logic             i_rst,
    input  logic             i_dcm_lock,
    input  logic             i_sw_reset_req,
    output logic [N_DOM-1:0] o_dom_rst,
    output logic             o_seq_done,
    output logic             o_tick_1M,
    output logic             o_tick_100K,
    output logic [2:0]       o_seq_state,
    output logic [7:0]       o_lock_loss_cnt,
    output logic             o_lock_fault
);

    // FSM encodings are visible on o_seq_state, so they are fixed values.
    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_STABLE    = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
`ifdef CLK_SEQ_WDOG_EN
    localparam logic [2:0] ST_FAULT     = 3'd4;
`endif

    localparam int unsigned STABLE_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int unsigned GAP_W    = (REL_GAP_CYC > 1) ? $clog2(REL_GAP_CYC) : 1;
    localparam int unsigned DIV1_W   = (DIV_1M > 1) ? $clog2(DIV_1M) : 1;
    localparam int unsigned DIV2_W   = (DIV_100K > 1) ? $clog2(DIV_100K) : 1;

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(REL_GAP_CYC - 1);
    localparam logic [DIV1_W-1:0]   DIV1_LAST   = DIV1_W'(DIV_1M - 1);
    localparam logic [DIV2_W-1:0]   DIV2_LAST   = DIV2_W'(DIV_100K - 1);
    // Only the top domain still in reset: the next release completes the sequence.
    localparam logic [N_DOM-1:0]    DOM_LAST    = N_DOM'(1) << (N_DOM - 1);

`ifdef CLK_SEQ_WDOG_EN
    localparam int unsigned         WDOG_W      = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WDOG_W-1:0]   WDOG_LAST   = WDOG_W'(WDOG_CYC - 1);
`endif

    if (N_DOM < 1 || N_DOM > 8 || LOCK_STABLE_CYC < 1 || REL_GAP_CYC < 1 || DIV_1M < 1 ||
        DIV_100K < 1 || WDOG_CYC < 1) begin : g_bad_param
        $error("clk_rst_seq: parameter out of range");
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    logic                r_lock_meta;
    logic                r_lock_s;
    logic [2:0]          r_state;
    logic [STABLE_W-1:0] r_stable_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [N_DOM-1:0]    r_dom_rst;
    logic                r_seq_done;
    logic [DIV1_W-1:0]   r_tick_cnt;
    logic [DIV2_W-1:0]   r_div_cnt;
    logic                r_tick_1M;
    logic                r_tick_100K;
    logic [7:0]          r_loss_cnt;
`ifdef CLK_SEQ_WDOG_EN
    logic [WDOG_W-1:0]   r_wdog_cnt;
    logic                r_lock_fault;
`endif

    // Next-state values
    logic [2:0]          w_state_nxt;
    logic [STABLE_W-1:0] w_stable_cnt_nxt;
    logic [GAP_W-1:0]    w_gap_cnt_nxt;
    logic [N_DOM-1:0]    w_dom_rst_nxt;
    logic                w_seq_done_nxt;
    logic [DIV1_W-1:0]   w_tick_cnt_nxt;
    logic [DIV2_W-1:0]   w_div_cnt_nxt;
    logic                w_tick_1M_nxt;
    logic                w_tick_100K_nxt;
    logic [7:0]          w_loss_cnt_nxt;
`ifdef CLK_SEQ_WDOG_EN
    logic [WDOG_W-1:0]   w_wdog_cnt_nxt;
    logic                w_lock_fault_nxt;
`endif

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_stable_cnt_nxt = r_stable_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_dom_rst_nxt    = r_dom_rst;
        w_seq_done_nxt   = r_seq_done;
        // Tick counters and enables are only live in RUN.
        w_tick_cnt_nxt   = '0;
        w_div_cnt_nxt    = '0;
        w_tick_1M_nxt    = 1'b0;
        w_tick_100K_nxt  = 1'b0;
        w_loss_cnt_nxt   = r_loss_cnt;
`ifdef CLK_SEQ_WDOG_EN
        w_wdog_cnt_nxt   = '0;
        w_lock_fault_nxt = r_lock_fault;
`endif

        case (r_state)
            ST_WAIT_LOCK: begin
                w_dom_rst_nxt    = '1;
                w_seq_done_nxt   = 1'b0;
                w_stable_cnt_nxt = '0;
                if (r_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end
            end

            ST_STABLE: begin
                w_dom_rst_nxt  = '1;
                w_seq_done_nxt = 1'b0;
                if (!r_lock_s) begin
                    w_state_nxt      = ST_WAIT_LOCK;
                    w_stable_cnt_nxt = '0;
                end else if (r_stable_cnt == STABLE_LAST) begin
                    w_state_nxt      = ST_RELEASE;
                    w_stable_cnt_nxt = '0;
                    w_gap_cnt_nxt    = '0;
                end else begin
                    w_stable_cnt_nxt = r_stable_cnt + STABLE_W'(1);
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!r_lock_s || i_sw_reset_req) begin
                    // Abort: lock loss wins over a simultaneous software request, and only
                    // lock loss is counted.
                    w_state_nxt      = ST_WAIT_LOCK;
                    w_dom_rst_nxt    = '1;
                    w_seq_done_nxt   = 1'b0;
                    w_stable_cnt_nxt = '0;
                    w_gap_cnt_nxt    = '0;
                    if (!r_lock_s && (r_loss_cnt != 8'hFF)) begin
                        w_loss_cnt_nxt = r_loss_cnt + 8'd1;
                    end
                end else if (r_state == ST_RELEASE) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_gap_cnt_nxt = '0;
                        // Shifting left clears the lowest still-asserted bit, which keeps
                        // releases strictly in index order.
                        w_dom_rst_nxt = r_dom_rst << 1;
                        if (r_dom_rst == DOM_LAST) begin
                            w_state_nxt    = ST_RUN;
                            w_seq_done_nxt = 1'b1;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    end
                end else begin
                    if (r_tick_cnt == DIV1_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_tick_1M_nxt  = 1'b1;
                        if (r_div_cnt == DIV2_LAST) begin
                            w_div_cnt_nxt   = '0;
                            w_tick_100K_nxt = 1'b1;
                        end else begin
                            w_div_cnt_nxt = r_div_cnt + DIV2_W'(1);
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + DIV1_W'(1);
                        w_div_cnt_nxt  = r_div_cnt;
                    end
                end
            end

`ifdef CLK_SEQ_WDOG_EN
            ST_FAULT: begin
                // Terminal until i_rst; lock and software requests are ignored.
                w_dom_rst_nxt    = '1;
                w_seq_done_nxt   = 1'b0;
                w_lock_fault_nxt = 1'b1;
            end
`endif

            default: begin
                w_state_nxt      = ST_WAIT_LOCK;
                w_dom_rst_nxt    = '1;
                w_seq_done_nxt   = 1'b0;
                w_stable_cnt_nxt = '0;
                w_gap_cnt_nxt    = '0;
            end
        endcase

`ifdef CLK_SEQ_WDOG_EN
        // Watchdog covers the whole lock-acquire phase and overrides the FSM when it expires.
        if ((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE)) begin
            if (r_wdog_cnt == WDOG_LAST) begin
                w_state_nxt      = ST_FAULT;
                w_lock_fault_nxt = 1'b1;
                w_dom_rst_nxt    = '1;
                w_seq_done_nxt   = 1'b0;
                w_stable_cnt_nxt = '0;
            end else if (w_state_nxt != ST_RELEASE) begin
                w_wdog_cnt_nxt = r_wdog_cnt + WDOG_W'(1);
            end
        end
`endif
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk_100M) begin
        if (i_rst) begin
            r_lock_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
            r_state      <= ST_WAIT_LOCK;
            r_stable_cnt <= '0;
            r_gap_cnt    <= '0;
            r_dom_rst    <= '1;
            r_seq_done   <= 1'b0;
            r_tick_cnt   <= '0;
            r_div_cnt    <= '0;
            r_tick_1M    <= 1'b0;
            r_tick_100K  <= 1'b0;
            r_loss_cnt   <= '0;
`ifdef CLK_SEQ_WDOG_EN
            r_wdog_cnt   <= '0;
            r_lock_fault <= 1'b0;
`endif
        end else begin
            r_lock_meta  <= i_dcm_lock;
            r_lock_s     <= r_lock_meta;
            r_state      <= w_state_nxt;
            r_stable_cnt <= w_stable_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_dom_rst    <= w_dom_rst_nxt;
            r_seq_done   <= w_seq_done_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_tick_1M    <= w_tick_1M_nxt;
            r_tick_100K  <= w_tick_100K_nxt;
            r_loss_cnt   <= w_loss_cnt_nxt;
`ifdef CLK_SEQ_WDOG_EN
            r_wdog_cnt   <= w_wdog_cnt_nxt;
            r_lock_fault <= w_lock_fault_nxt;
`endif
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign o_dom_rst       = r_dom_rst;
    assign o_seq_done      = r_seq_done;
    assign o_tick_1M       = r_tick_1M;
    assign o_tick_100K     = r_tick_100K;
    assign o_seq_state     = r_state;
    assign o_lock_loss_cnt = r_loss_cnt;
`ifdef CLK_SEQ_WDOG_EN
    assign o_lock_fault    = r_lock_fault;
`else
    assign o_lock_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_clk_rst_seq
//   Directed and randomised stimulus for clk_rst_seq, checked every cycle against a
//   phase/age reference model plus directed constant expectations.
// ---------------------------------------------------------------------------------------------
module tb_clk_rst_seq;

    localparam int unsigned LSC  = 8;
    localparam int unsigned GAP  = 4;
    localparam int unsigned NDOM = 4;
    localparam int unsigned D1   = 5;
    localparam int unsigned D2   = 3;
    localparam int unsigned WDOG = 50;

    logic       clk;
    logic       rst;
    logic       dcm_lock;
    logic       sw_req;
    logic [3:0] dom_rst;
    logic       seq_done;
    logic       tick_1m;
    logic       tick_100k;
    logic [2:0] seq_state;
    logic [7:0] loss_cnt;
    logic       lock_fault;

    int n_tests;
    int n_fail;

    // Reference model: phase plus "how long since" counters.
    bit m_s1, m_s2;
    int m_phase;     // 0 wait, 1 stable, 2 release, 3 run, 4 fault
    int m_stable;    // qualifying lock cycles seen in STABLE
    int m_rel_age;   // edges since RELEASE entry
    int m_run_age;   // edges since RUN entry
    int m_loss;
    int m_wdog;      // cycles spent acquiring lock

    clk_rst_seq #(
        .LOCK_STABLE_CYC(LSC),
        .REL_GAP_CYC    (GAP),
        .N_DOM          (NDOM),
        .DIV_1M         (D1),
        .DIV_100K       (D2),
        .WDOG_CYC       (WDOG)
    ) u_dut (
        .i_clk_100M     (clk),
        .i_rst          (rst),
        .i_dcm_lock     (dcm_lock),
        .i_sw_reset_req (sw_req),
        .o_dom_rst      (dom_rst),
        .o_seq_done     (seq_done),
        .o_tick_1M      (tick_1m),
        .o_tick_100K    (tick_100k),
        .o_seq_state    (seq_state),
        .o_lock_loss_cnt(loss_cnt),
        .o_lock_fault   (lock_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit lock, input bit sw, input bit r);
        bit ls;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_phase = 0; m_stable = 0;
            m_rel_age = 0; m_run_age = 0; m_loss = 0; m_wdog = 0;
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lock;
`ifdef CLK_SEQ_WDOG_EN
        if (m_phase <= 1) begin
            m_wdog++;
            if (m_wdog == WDOG) begin
                m_phase = 4;
                return;
            end
        end
`endif
        case (m_phase)
            0: if (ls) begin m_phase = 1; m_stable = 0; end
            1: begin
                if (!ls) m_phase = 0;
                else begin
                    m_stable++;
                    if (m_stable == LSC) begin m_phase = 2; m_rel_age = 0; m_wdog = 0; end
                end
            end
            2, 3: begin
                if (!ls) begin
                    m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
                    m_phase = 0;
                end else if (sw) begin
                    m_phase = 0;
                end else if (m_phase == 2) begin
                    m_rel_age++;
                    if (m_rel_age == NDOM * GAP) begin m_phase = 3; m_run_age = 0; end
                end else begin
                    m_run_age++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        logic [3:0] all_ones;
        logic [3:0] e_dom;
        bit         e_t1, e_t2;
        all_ones = 4'hF;
        if (m_phase == 2)      e_dom = all_ones << (m_rel_age / GAP);
        else if (m_phase == 3) e_dom = 4'h0;
        else                   e_dom = all_ones;
        e_t1 = (m_phase == 3) && (m_run_age > 0) && (m_run_age % D1 == 0);
        e_t2 = (m_phase == 3) && (m_run_age > 0) && (m_run_age % (D1 * D2) == 0);
        chk("m_dom_rst", 32'(dom_rst), 32'(e_dom));
        chk("m_seq_done", 32'(seq_done), 32'(m_phase == 3));
        chk("m_tick_1M", 32'(tick_1m), 32'(e_t1));
        chk("m_tick_100K", 32'(tick_100k), 32'(e_t2));
        chk("m_seq_state", 32'(seq_state), 32'(m_phase));
        chk("m_loss_cnt", 32'(loss_cnt), 32'(m_loss));
        chk("m_lock_fault", 32'(lock_fault), 32'(m_phase == 4));
    endtask

    task automatic step(input logic lock, input logic sw);
        dcm_lock = lock;
        sw_req   = sw;
        @(posedge clk);
        model_edge(lock, sw, rst);
        #1;
        check_model();
    endtask

    task automatic do_reset(input logic lock);
        rst = 1'b1;
        step(lock, 1'b0);
        step(lock, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_to_run(input string tag);
        int k;
        k = 0;
        while (seq_state !== 3'd3 && k < 80) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk(tag, 32'(seq_state), 32'd3);
    endtask

    initial begin
        int n1, n2, alone, k;
        bit lock_v;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        dcm_lock = 1'b0;
        sw_req   = 1'b0;

        // Reset state
        do_reset(1'b1);
        chk("rst_dom", 32'(dom_rst), 32'hF);
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_done", 32'(seq_done), 32'd0);
        chk("rst_loss", 32'(loss_cnt), 32'd0);

        // 1. Qualification and ordered release
        for (int s = 1; s <= 27; s++) begin
            step(1'b1, 1'b0);
            if (s == 2)  chk("t1_wait", 32'(seq_state), 32'd0);
            if (s == 3)  chk("t1_stable_in", 32'(seq_state), 32'd1);
            if (s == 10) chk("t1_stable_last", 32'(seq_state), 32'd1);
            if (s == 11) chk("t1_release_in", 32'(seq_state), 32'd2);
            if (s == 14) chk("t1_dom_F", 32'(dom_rst), 32'hF);
            if (s == 15) chk("t1_dom_E", 32'(dom_rst), 32'hE);
            if (s == 19) chk("t1_dom_C", 32'(dom_rst), 32'hC);
            if (s == 23) chk("t1_dom_8", 32'(dom_rst), 32'h8);
            if (s == 26) chk("t1_done_early", 32'(seq_done), 32'd0);
            if (s == 27) begin
                chk("t1_dom_0", 32'(dom_rst), 32'h0);
                chk("t1_done", 32'(seq_done), 32'd1);
                chk("t1_run", 32'(seq_state), 32'd3);
            end
        end

        // 2. Tick enables over 60 RUN cycles
        n1 = 0; n2 = 0; alone = 0;
        for (int s = 0; s < 60; s++) begin
            step(1'b1, 1'b0);
            if (tick_1m === 1'b1) n1++;
            if (tick_100k === 1'b1) n2++;
            if (tick_100k === 1'b1 && tick_1m !== 1'b1) alone++;
        end
        chk("t2_n_1M", 32'(n1), 32'd12);
        chk("t2_n_100K", 32'(n2), 32'd4);
        chk("t2_100K_alone", 32'(alone), 32'd0);

        // 3. One-cycle lock glitch at STABLE count 5
        do_reset(1'b1);
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0);
        chk("t3_stable_in", 32'(seq_state), 32'd1);
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("t3_still_stable", 32'(seq_state), 32'd1);
        step(1'b1, 1'b0);
        chk("t3_back_wait", 32'(seq_state), 32'd0);
        chk("t3_loss_0", 32'(loss_cnt), 32'd0);
        step(1'b1, 1'b0);
        chk("t3_restable", 32'(seq_state), 32'd1);
        for (int s = 0; s < 7; s++) step(1'b1, 1'b0);
        chk("t3_requal_last", 32'(seq_state), 32'd1);
        step(1'b1, 1'b0);
        chk("t3_release", 32'(seq_state), 32'd2);

        // 5. sw request coincident with lock loss, then sw alone in RELEASE
        do_reset(1'b1);
        run_to_run("t5_reach_run");
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t5_both_dom", 32'(dom_rst), 32'hF);
        chk("t5_both_done", 32'(seq_done), 32'd0);
        chk("t5_both_loss", 32'(loss_cnt), 32'd1);
        k = 0;
        while (dom_rst !== 4'hC && k < 80) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk("t5_dom_C", 32'(dom_rst), 32'hC);
        step(1'b1, 1'b1);
        chk("t5_sw_dom", 32'(dom_rst), 32'hF);
        chk("t5_sw_state", 32'(seq_state), 32'd0);
        chk("t5_sw_loss", 32'(loss_cnt), 32'd1);

        // 4. Repeated lock loss in RUN, counter saturates
        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            run_to_run("t4_reach_run");
            k = int'($urandom_range(0, 6));
            for (int s = 0; s < k; s++) step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            chk("t4_pre_abort", 32'(seq_done), 32'd1);
            step(1'b0, 1'b0);
            chk("t4_dom", 32'(dom_rst), 32'hF);
            chk("t4_done", 32'(seq_done), 32'd0);
            chk("t4_loss", 32'(loss_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        chk("t4_saturated", 32'(loss_cnt), 32'd255);

        // Randomised lock / software-request traffic against the model
        do_reset(1'b1);
        lock_v = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (lock_v) lock_v = ($urandom_range(0, 39) != 0);
            else        lock_v = ($urandom_range(0, 2) == 0);
            step(lock_v, ($urandom_range(0, 29) == 0));
        end

`ifdef CLK_SEQ_WDOG_EN
        // 6. Watchdog expiry and sticky FAULT
        do_reset(1'b0);
        for (int s = 0; s < 49; s++) step(1'b0, 1'b0);
        chk("t6_pre_state", 32'(seq_state), 32'd0);
        chk("t6_pre_fault", 32'(lock_fault), 32'd0);
        step(1'b0, 1'b0);
        chk("t6_state", 32'(seq_state), 32'd4);
        chk("t6_fault", 32'(lock_fault), 32'd1);
        for (int s = 0; s < 30; s++) step(1'b1, (s % 7) == 3);
        chk("t6_hold_state", 32'(seq_state), 32'd4);
        chk("t6_hold_fault", 32'(lock_fault), 32'd1);
        chk("t6_hold_dom", 32'(dom_rst), 32'hF);
        do_reset(1'b1);
        chk("t6_rst_state", 32'(seq_state), 32'd0);
        chk("t6_rst_fault", 32'(lock_fault), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
